game_sequencer: RTL and testbench

Top-level play-state controller for the dinosaur game. It sequences the score datapath: clears it on a new game, issues one-cycle score-increment enables at the frame-derived rate while running, and freezes it on pause or game over. It also tracks the session high score and a speed level for the obstacle/scroll logic. It sits between the button/collision inputs and the score counter, scroller and display blocks.

---
 rtl/game_sequencer_pkg.sv | 21 ++
 rtl/game_sequencer_btn_edge.sv | 25 ++
 rtl/game_sequencer.sv | 157 +++++++++++++++
 tb/tb_game_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
// rtl/game_sequencer_pkg.sv - shared state encodings and score defaults for the play-state controller
package game_sequencer_pkg;

   // Score counter length and frames-per-point used across the score datapath
   localparam int SCORE_LENGTH        = 10;
   localparam int SCORE_PERIOD_FRAMES = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CNTDN  = 3'd1,
      ST_RUN    = 3'd2,
      ST_PAUSED = 3'd3,
      ST_OVER   = 3'd4
   } state_t;

   // Width of a counter that runs 0..n-1; never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/game_sequencer_btn_edge.sv
// rtl/game_sequencer_btn_edge.sv - button register with rising-edge detect
module game_sequencer_btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_rise
);

   logic r_cur;
   logic r_prev;

   // sample the button level and keep one cycle of history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cur  <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_cur  <= i_btn;
         r_prev <= r_cur;
      end
   end

   assign o_rise = r_cur & ~r_prev;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - play-state FSM, score pacing, speed level and high score
module game_sequencer
   import game_sequencer_pkg::*;
#(
   parameter int SCORE_W      = SCORE_LENGTH,
   parameter int SCORE_PERIOD = SCORE_PERIOD_FRAMES,
   parameter int SPEED_STEP   = 100,
   parameter int MAX_LEVEL    = 7,
   parameter int COUNTDOWN    = 60
) (
   input  logic               clk3,
   input  logic               reset,
   input  logic               start_btn,
   input  logic               pause_btn,
   input  logic               collision,
   input  logic               frame_tick,
   input  logic [SCORE_W-1:0] score,
   output logic [2:0]         state,
   output logic               score_clr,
   output logic               score_en,
   output logic [2:0]         speed_lvl,
   output logic [SCORE_W-1:0] hi_score,
   output logic               new_record,
   output logic               game_over
);

   localparam int FRAME_W = cnt_width(SCORE_PERIOD);
   localparam int STEP_W  = cnt_width(SPEED_STEP);
   localparam int CD_W    = cnt_width(COUNTDOWN);

   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SCORE_PERIOD - 1);
   localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SPEED_STEP - 1);
   localparam logic [CD_W-1:0]    CD_LAST    = CD_W'(COUNTDOWN - 1);
   localparam logic [2:0]         LVL_MAX    = 3'(MAX_LEVEL);

   state_t               r_state;
   logic                 r_score_clr;
   logic                 r_score_en;
   logic [2:0]           r_speed_lvl;
   logic [SCORE_W-1:0]   r_hi_score;
   logic                 r_new_record;
   logic                 r_game_over;
   logic [FRAME_W-1:0]   r_frame_cnt;
   logic [STEP_W-1:0]    r_step_cnt;
   logic [CD_W-1:0]      r_cd_cnt;

   logic                 w_start_evt;
   logic                 w_pause_evt;
   logic                 w_score_sat;

   game_sequencer_btn_edge u_start_edge (
      .clk    (clk3),
      .rst    (reset),
      .i_btn  (start_btn),
      .o_rise (w_start_evt)
   );

   game_sequencer_btn_edge u_pause_edge (
      .clk    (clk3),
      .rst    (reset),
      .i_btn  (pause_btn),
      .o_rise (w_pause_evt)
   );

   // A full score counter must not be bumped past its maximum
   assign w_score_sat = &score;

   // play-state FSM with score pacing, speed stepping and high-score capture
   always_ff @(posedge clk3 or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_score_clr  <= 1'b0;
         r_score_en   <= 1'b0;
         r_speed_lvl  <= 3'd0;
         r_hi_score   <= '0;
         r_new_record <= 1'b0;
         r_game_over  <= 1'b0;
         r_frame_cnt  <= '0;
         r_step_cnt   <= '0;
         r_cd_cnt     <= '0;
      end else begin
         r_score_clr <= 1'b0;
         r_score_en  <= 1'b0;
         case (r_state)
            ST_IDLE, ST_OVER: begin
               // pause is ignored here, so start always wins a same-cycle tie
               if (w_start_evt) begin
                  r_state      <= ST_CNTDN;
                  r_score_clr  <= 1'b1;
                  r_game_over  <= 1'b0;
                  r_speed_lvl  <= 3'd0;
                  r_step_cnt   <= '0;
                  r_frame_cnt  <= '0;
                  r_cd_cnt     <= '0;
                  r_new_record <= 1'b0;
               end
            end
            ST_CNTDN: begin
               if (frame_tick) begin
                  if (r_cd_cnt == CD_LAST) begin
                     r_cd_cnt <= '0;
                     r_state  <= ST_RUN;
                  end else begin
                     r_cd_cnt <= r_cd_cnt + CD_W'(1);
                  end
               end
            end
            ST_RUN: begin
               if (collision) begin
                  r_state     <= ST_OVER;
                  r_game_over <= 1'b1;
                  if (score > r_hi_score) begin
                     r_hi_score   <= score;
                     r_new_record <= 1'b1;
                  end
               end else if (w_pause_evt) begin
                  r_state <= ST_PAUSED;
               end else if (frame_tick) begin
                  if (r_frame_cnt == FRAME_LAST) begin
                     r_frame_cnt <= '0;
                     if (!w_score_sat) begin
                        r_score_en <= 1'b1;
                        if (r_step_cnt == STEP_LAST) begin
                           r_step_cnt <= '0;
                           if (r_speed_lvl != LVL_MAX) begin
                              r_speed_lvl <= r_speed_lvl + 3'd1;
                           end
                        end else begin
                           r_step_cnt <= r_step_cnt + STEP_W'(1);
                        end
                     end
                  end else begin
                     r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
                  end
               end
            end
            ST_PAUSED: begin
               if (w_pause_evt) begin
                  r_state <= ST_RUN;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign state      = r_state;
   assign score_clr  = r_score_clr;
   assign score_en   = r_score_en;
   assign speed_lvl  = r_speed_lvl;
   assign hi_score   = r_hi_score;
   assign new_record = r_new_record;
   assign game_over  = r_game_over;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - scoreboard bench for the play-state controller
module tb_game_sequencer;
   import game_sequencer_pkg::*;

   localparam int SW = 10;

   logic          clk3       = 1'b0;
   logic          reset      = 1'b1;
   logic          start_btn  = 1'b0;
   logic          pause_btn  = 1'b0;
   logic          collision  = 1'b0;
   logic          frame_tick = 1'b0;
   logic [SW-1:0] score      = '0;
   logic [2:0]    state;
   logic          score_clr;
   logic          score_en;
   logic [2:0]    speed_lvl;
   logic [SW-1:0] hi_score;
   logic          new_record;
   logic          game_over;

   typedef struct packed {
      logic [2:0]    st;
      logic          clr;
      logic          en;
      logic [2:0]    lvl;
      logic [SW-1:0] hi;
      logic          rec;
      logic          over;
   } snap_t;

   snap_t      exp_q[$];
   int         checks  = 0;
   int         errors  = 0;
   int         obs_en  = 0;
   logic       tick_s  = 1'b0;
   logic [2:0] prev_st = 3'd0;

   int            m_en    = 0;
   int            m_phase = 0;
   logic [SW-1:0] m_hi    = '0;
   logic          m_rec   = 1'b0;
   int            base    = 0;

   game_sequencer #(
      .SCORE_W      (SW),
      .SCORE_PERIOD (2),
      .SPEED_STEP   (2),
      .MAX_LEVEL    (3),
      .COUNTDOWN    (60)
   ) dut (
      .clk3       (clk3),
      .reset      (reset),
      .start_btn  (start_btn),
      .pause_btn  (pause_btn),
      .collision  (collision),
      .frame_tick (frame_tick),
      .score      (score),
      .state      (state),
      .score_clr  (score_clr),
      .score_en   (score_en),
      .speed_lvl  (speed_lvl),
      .hi_score   (hi_score),
      .new_record (new_record),
      .game_over  (game_over)
   );

   always #5 clk3 = ~clk3;

   always @(posedge clk3) tick_s <= frame_tick;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int lvl_of(input int n);
      return (n / 2 > 3) ? 3 : n / 2;
   endfunction

   task automatic push(input logic [2:0] st, input logic clr, input logic en, input logic over);
      snap_t s;
      s = '{st, clr, en, 3'(lvl_of(m_en)), m_hi, m_rec, over};
      exp_q.push_back(s);
   endtask

   // monitor: every clear, increment or state change pops one expected snapshot
   always @(negedge clk3) begin : monitor
      snap_t obs;
      snap_t e;
      if (reset) begin
         prev_st = 3'd0;
      end else begin
         obs = '{state, score_clr, score_en, speed_lvl, hi_score, new_record, game_over};
         if (state != prev_st || score_clr || score_en) begin
            if (score_en) check("en_one_cycle_after_tick", int'(tick_s), 1);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: got %h expected none", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  errors++;
                  $display("FAIL event_snapshot: got %h expected %h (st,clr,en,lvl,hi,rec,over)", obs, e);
               end
            end
            if (score_en) obs_en++;
         end
         prev_st = state;
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk3);
         #1;
      end
   endtask

   task automatic raw_tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
   endtask

   task automatic pulse_pause();
      pause_btn = 1'b1;
      cyc();
      pause_btn = 1'b0;
      cyc();
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         m_phase++;
         if (m_phase == 2) begin
            m_phase = 0;
            if (!(&score)) begin
               m_en++;
               push(ST_RUN, 1'b0, 1'b1, 1'b0);
            end
         end
         raw_tick();
      end
   endtask

   task automatic start_game(input logic with_pause);
      m_en    = 0;
      m_phase = 0;
      m_rec   = 1'b0;
      push(ST_CNTDN, 1'b1, 1'b0, 1'b0);
      start_btn = 1'b1;
      pause_btn = with_pause;
      cyc();
      start_btn = 1'b0;
      pause_btn = 1'b0;
      cyc();
      push(ST_RUN, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 60; i++) begin
         if (i == 30) pulse_pause();
         if (i == 59) check("cntdn_after_59_ticks", int'(state), 1);
         raw_tick();
      end
      check("run_after_60_ticks", int'(state), 2);
   endtask

   task automatic collide(input logic [SW-1:0] s, input logic with_pause);
      score = s;
      if (with_pause) begin
         pause_btn = 1'b1;
         cyc();
      end
      if (s > m_hi) begin
         m_hi  = s;
         m_rec = 1'b1;
      end
      push(ST_OVER, 1'b0, 1'b0, 1'b1);
      collision = 1'b1;
      cyc();
      collision = 1'b0;
      pause_btn = 1'b0;
      cyc();
   endtask

   initial begin
      cyc(2);
      check("rst_state", int'(state), 0);
      check("rst_clr", int'(score_clr), 0);
      check("rst_en", int'(score_en), 0);
      check("rst_lvl", int'(speed_lvl), 0);
      check("rst_hi", int'(hi_score), 0);
      check("rst_rec", int'(new_record), 0);
      check("rst_over", int'(game_over), 0);
      reset = 1'b0;
      cyc(3);
      check("idle_without_start", int'(state), 0);

      // game 1: pacing, ignored start, pause with phase kept, speed saturation
      start_game(1'b0);
      base = obs_en;
      run_ticks(10);
      check("five_en_in_ten_ticks", obs_en - base, 5);
      start_btn = 1'b1;
      cyc();
      start_btn = 1'b0;
      cyc(2);
      check("start_ignored_in_run", int'(state), 2);
      run_ticks(1);
      push(ST_PAUSED, 1'b0, 1'b0, 1'b0);
      pulse_pause();
      base = obs_en;
      for (int i = 0; i < 20; i++) raw_tick();
      check("no_en_while_paused", obs_en - base, 0);
      push(ST_RUN, 1'b0, 1'b0, 1'b0);
      pulse_pause();
      base = obs_en;
      run_ticks(1);
      check("phase_kept_after_resume", obs_en - base, 1);
      run_ticks(28);
      check("speed_lvl_saturated", int'(speed_lvl), 3);
      collide(10'd20, 1'b0);
      check("hi_after_game1", int'(hi_score), 20);

      // game 2: collision and pause event together
      start_game(1'b0);
      run_ticks(4);
      collide(10'd37, 1'b1);
      check("over_state", int'(state), 4);
      check("hi_37", int'(hi_score), 37);
      check("record_set", int'(new_record), 1);

      // game 3: start+pause together in OVER, saturated score, lower result
      start_game(1'b1);
      run_ticks(2);
      score = '1;
      base  = obs_en;
      run_ticks(4);
      check("no_en_when_saturated", obs_en - base, 0);
      collide(10'd12, 1'b0);
      check("hi_kept_37", int'(hi_score), 37);
      check("record_clear", int'(new_record), 0);

      // game 4: asynchronous reset mid-run
      score = '0;
      start_game(1'b0);
      run_ticks(3);
      check("queue_drained_before_reset", exp_q.size(), 0);
      @(posedge clk3);
      #3;
      reset = 1'b1;
      #1;
      check("async_state", int'(state), 0);
      check("async_clr", int'(score_clr), 0);
      check("async_en", int'(score_en), 0);
      check("async_lvl", int'(speed_lvl), 0);
      check("async_hi", int'(hi_score), 0);
      check("async_rec", int'(new_record), 0);
      check("async_over", int'(game_over), 0);
      cyc(2);
      reset = 1'b0;
      cyc(3);
      check("queue_empty_at_end", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
